// File: rtl/pact_lsu_axi_serializer.sv
// Serializes the cache's separate AXI read and write channels onto one
// single-outstanding AXI master port, with sticky protocol/response error flags.
module pact_lsu_axi_serializer #(
  parameter int BW_ADDR        = 32,
  parameter int BW_AXI_DATA    = 32,
  parameter int BW_AXI_TID     = 4,
  parameter int WRITE_PRIORITY = 1
) (
  input  logic                     clk,
  input  logic                     rstnn,

  input  logic [BW_AXI_TID-1:0]    sxarid,
  input  logic [BW_ADDR-1:0]       sxaraddr,
  input  logic [7:0]               sxarlen,
  input  logic [2:0]               sxarsize,
  input  logic [1:0]               sxarburst,
  input  logic                     sxarvalid,
  output logic                     sxarready,

  output logic [BW_AXI_TID-1:0]    sxrid,
  output logic [BW_AXI_DATA-1:0]   sxrdata,
  output logic [1:0]               sxrresp,
  output logic                     sxrlast,
  output logic                     sxrvalid,
  input  logic                     sxrready,

  input  logic [BW_AXI_TID-1:0]    sxawid,
  input  logic [BW_ADDR-1:0]       sxawaddr,
  input  logic [7:0]               sxawlen,
  input  logic [2:0]               sxawsize,
  input  logic [1:0]               sxawburst,
  input  logic                     sxawvalid,
  output logic                     sxawready,

  input  logic [BW_AXI_TID-1:0]    sxwid,
  input  logic [BW_AXI_DATA-1:0]   sxwdata,
  input  logic [BW_AXI_DATA/8-1:0] sxwstrb,
  input  logic                     sxwlast,
  input  logic                     sxwvalid,
  output logic                     sxwready,

  output logic [BW_AXI_TID-1:0]    sxbid,
  output logic [1:0]               sxbresp,
  output logic                     sxbvalid,
  input  logic                     sxbready,

  output logic [BW_AXI_TID-1:0]    mxarid,
  output logic [BW_ADDR-1:0]       mxaraddr,
  output logic [7:0]               mxarlen,
  output logic [2:0]               mxarsize,
  output logic [1:0]               mxarburst,
  output logic                     mxarvalid,
  input  logic                     mxarready,

  input  logic [BW_AXI_TID-1:0]    mxrid,
  input  logic [BW_AXI_DATA-1:0]   mxrdata,
  input  logic [1:0]               mxrresp,
  input  logic                     mxrlast,
  input  logic                     mxrvalid,
  output logic                     mxrready,

  output logic [BW_AXI_TID-1:0]    mxawid,
  output logic [BW_ADDR-1:0]       mxawaddr,
  output logic [7:0]               mxawlen,
  output logic [2:0]               mxawsize,
  output logic [1:0]               mxawburst,
  output logic                     mxawvalid,
  input  logic                     mxawready,

  output logic [BW_AXI_TID-1:0]    mxwid,
  output logic [BW_AXI_DATA-1:0]   mxwdata,
  output logic [BW_AXI_DATA/8-1:0] mxwstrb,
  output logic                     mxwlast,
  output logic                     mxwvalid,
  input  logic                     mxwready,

  input  logic [BW_AXI_TID-1:0]    mxbid,
  input  logic [1:0]               mxbresp,
  input  logic                     mxbvalid,
  output logic                     mxbready,

  input  logic                     clear,
  output logic                     error_rresp,
  output logic                     error_bresp,
  output logic                     error_rlast,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       error_rresp_q, error_rresp_d;
  logic       error_bresp_q, error_bresp_d;
  logic       error_rlast_q, error_rlast_d;

  logic st_rd_addr, st_rd_data, st_wr_addr, st_wr_data, st_wr_resp;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic rlast_bad;

  assign st_rd_addr = (state_q == S_RD_ADDR);
  assign st_rd_data = (state_q == S_RD_DATA);
  assign st_wr_addr = (state_q == S_WR_ADDR);
  assign st_wr_data = (state_q == S_WR_DATA);
  assign st_wr_resp = (state_q == S_WR_RESP);

  // Payload fields pass through ungated; only valid/ready depend on state.
  assign mxarid    = sxarid;
  assign mxaraddr  = sxaraddr;
  assign mxarlen   = sxarlen;
  assign mxarsize  = sxarsize;
  assign mxarburst = sxarburst;
  assign mxarvalid = st_rd_addr & sxarvalid;
  assign sxarready = st_rd_addr & mxarready;

  assign sxrid     = mxrid;
  assign sxrdata   = mxrdata;
  assign sxrresp   = mxrresp;
  assign sxrlast   = mxrlast;
  assign sxrvalid  = st_rd_data & mxrvalid;
  assign mxrready  = st_rd_data & sxrready;

  assign mxawid    = sxawid;
  assign mxawaddr  = sxawaddr;
  assign mxawlen   = sxawlen;
  assign mxawsize  = sxawsize;
  assign mxawburst = sxawburst;
  assign mxawvalid = st_wr_addr & sxawvalid;
  assign sxawready = st_wr_addr & mxawready;

  assign mxwid     = sxwid;
  assign mxwdata   = sxwdata;
  assign mxwstrb   = sxwstrb;
  assign mxwlast   = sxwlast;
  assign mxwvalid  = st_wr_data & sxwvalid;
  assign sxwready  = st_wr_data & mxwready;

  assign sxbid     = mxbid;
  assign sxbresp   = mxbresp;
  assign sxbvalid  = st_wr_resp & mxbvalid;
  assign mxbready  = st_wr_resp & sxbready;

  assign ar_hs = mxarvalid & mxarready;
  assign r_hs  = sxrvalid & sxrready;
  assign aw_hs = mxawvalid & mxawready;
  assign w_hs  = mxwvalid & mxwready;
  assign b_hs  = sxbvalid & sxbready;

  assign rlast_bad = r_hs & (mxrlast != (beat_cnt_q == len_q));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sxawvalid && (!sxarvalid || (WRITE_PRIORITY != 0))) state_d = S_WR_ADDR;
        else if (sxarvalid)                                     state_d = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          len_d      = sxarlen;
          beat_cnt_d = '0;
          state_d    = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        // Completion follows rlast, not the beat count, so a late rlast keeps us here.
        if (r_hs) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 8'd1;
          if (mxrlast)          state_d    = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        if (aw_hs) begin
          len_d   = sxawlen;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_hs && sxwlast) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a set event wins over a coincident clear.
  always_comb begin
    error_rresp_d = (r_hs && (mxrresp != 2'b00)) | (error_rresp_q & ~clear);
    error_bresp_d = (b_hs && (mxbresp != 2'b00)) | (error_bresp_q & ~clear);
    error_rlast_d = rlast_bad | (error_rlast_q & ~clear);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      error_rresp_q <= 1'b0;
      error_bresp_q <= 1'b0;
      error_rlast_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      error_rresp_q <= error_rresp_d;
      error_bresp_q <= error_bresp_d;
      error_rlast_q <= error_rlast_d;
    end
  end

  assign error_rresp = error_rresp_q;
  assign error_bresp = error_bresp_q;
  assign error_rlast = error_rlast_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pact_lsu_axi_serializer.sv
// Scoreboard bench: two serializers (write-priority and read-priority) driven
// with directed transactions; a monitor checks every handshake in order.
module tb_pact_lsu_axi_serializer;

  localparam int K_AR = 0, K_AW = 1, K_W = 2, K_R = 3, K_B = 4;
  localparam int TMO  = 40;

  typedef struct packed {
    logic [3:0]  dut;
    logic [3:0]  kind;
    logic [3:0]  id;
    logic [4:0]  ctl;
    logic [31:0] val;
    logic [7:0]  aux;
    logic        last;
  } ev_t;

  logic clk, rstnn, clear;

  // shared payload inputs and always-ready sinks
  logic [3:0]  sxarid, sxawid, sxwid, mxrid, mxbid;
  logic [31:0] sxaraddr, sxawaddr, sxwdata, mxrdata;
  logic [7:0]  sxarlen, sxawlen;
  logic [2:0]  sxarsize, sxawsize;
  logic [1:0]  sxarburst, sxawburst, mxrresp, mxbresp;
  logic [3:0]  sxwstrb;
  logic        sxwlast, mxrlast;
  logic        sxrready, sxbready, mxarready, mxawready, mxwready;

  // per-instance valids and outputs
  logic [1:0]  sxarvalid, sxawvalid, sxwvalid, mxrvalid, mxbvalid;
  logic [1:0]  sxarready, sxrlast, sxrvalid, sxawready, sxwready, sxbvalid;
  logic [1:0]  mxarvalid, mxrready, mxawvalid, mxwlast, mxwvalid, mxbready;
  logic [1:0]  error_rresp, error_bresp, error_rlast, busy;
  logic [3:0]  sxrid [2], sxbid [2], mxarid [2], mxawid [2], mxwid [2], mxwstrb [2];
  logic [31:0] sxrdata [2], mxaraddr [2], mxawaddr [2], mxwdata [2];
  logic [1:0]  sxrresp [2], sxbresp [2], mxarburst [2], mxawburst [2];
  logic [7:0]  mxarlen [2], mxawlen [2];
  logic [2:0]  mxarsize [2], mxawsize [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pact_lsu_axi_serializer #(
      .BW_ADDR(32), .BW_AXI_DATA(32), .BW_AXI_TID(4), .WRITE_PRIORITY(g == 0 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rstnn(rstnn),
      .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
      .sxarburst(sxarburst), .sxarvalid(sxarvalid[g]), .sxarready(sxarready[g]),
      .sxrid(sxrid[g]), .sxrdata(sxrdata[g]), .sxrresp(sxrresp[g]), .sxrlast(sxrlast[g]),
      .sxrvalid(sxrvalid[g]), .sxrready(sxrready),
      .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
      .sxawburst(sxawburst), .sxawvalid(sxawvalid[g]), .sxawready(sxawready[g]),
      .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast),
      .sxwvalid(sxwvalid[g]), .sxwready(sxwready[g]),
      .sxbid(sxbid[g]), .sxbresp(sxbresp[g]), .sxbvalid(sxbvalid[g]), .sxbready(sxbready),
      .mxarid(mxarid[g]), .mxaraddr(mxaraddr[g]), .mxarlen(mxarlen[g]), .mxarsize(mxarsize[g]),
      .mxarburst(mxarburst[g]), .mxarvalid(mxarvalid[g]), .mxarready(mxarready),
      .mxrid(mxrid), .mxrdata(mxrdata), .mxrresp(mxrresp), .mxrlast(mxrlast),
      .mxrvalid(mxrvalid[g]), .mxrready(mxrready[g]),
      .mxawid(mxawid[g]), .mxawaddr(mxawaddr[g]), .mxawlen(mxawlen[g]), .mxawsize(mxawsize[g]),
      .mxawburst(mxawburst[g]), .mxawvalid(mxawvalid[g]), .mxawready(mxawready),
      .mxwid(mxwid[g]), .mxwdata(mxwdata[g]), .mxwstrb(mxwstrb[g]), .mxwlast(mxwlast[g]),
      .mxwvalid(mxwvalid[g]), .mxwready(mxwready),
      .mxbid(mxbid), .mxbresp(mxbresp), .mxbvalid(mxbvalid[g]), .mxbready(mxbready[g]),
      .clear(clear), .error_rresp(error_rresp[g]), .error_bresp(error_bresp[g]),
      .error_rlast(error_rlast[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ev_t  exp_q[$];

  function automatic ev_t mk(input int k, input int kind, input logic [3:0] id,
                             input logic [4:0] ctl, input logic [31:0] val,
                             input logic [7:0] aux, input logic last);
    ev_t e;
    e.dut = k[3:0]; e.kind = kind[3:0]; e.id = id; e.ctl = ctl;
    e.val = val; e.aux = aux; e.last = last;
    return e;
  endfunction

  function automatic logic hs(input int k, input int kind);
    case (kind)
      K_AR:    return mxarvalid[k] & mxarready;
      K_AW:    return mxawvalid[k] & mxawready;
      K_W:     return mxwvalid[k] & mxwready;
      K_R:     return sxrvalid[k] & sxrready;
      default: return sxbvalid[k] & sxbready;
    endcase
  endfunction

  function automatic ev_t observe(input int k, input int kind);
    case (kind)
      K_AR:    return mk(k, kind, mxarid[k], {mxarsize[k], mxarburst[k]}, mxaraddr[k], mxarlen[k], 1'b0);
      K_AW:    return mk(k, kind, mxawid[k], {mxawsize[k], mxawburst[k]}, mxawaddr[k], mxawlen[k], 1'b0);
      K_W:     return mk(k, kind, mxwid[k], 5'd0, mxwdata[k], {4'h0, mxwstrb[k]}, mxwlast[k]);
      K_R:     return mk(k, kind, sxrid[k], 5'd0, sxrdata[k], {6'd0, sxrresp[k]}, sxrlast[k]);
      default: return mk(k, kind, sxbid[k], 5'd0, 32'd0, {6'd0, sxbresp[k]}, 1'b0);
    endcase
  endfunction

  function automatic logic [13:0] zero_vec(input int k);
    return {sxarready[k], sxrvalid[k], sxawready[k], sxwready[k], sxbvalid[k],
            mxarvalid[k], mxrready[k], mxawvalid[k], mxwvalid[k], mxbready[k],
            busy[k], error_rresp[k], error_bresp[k], error_rlast[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor_step();
    ev_t got, e;
    if (rstnn !== 1'b1) return;
    for (int k = 0; k < 2; k++) begin
      for (int kind = 0; kind < 5; kind++) begin
        if (hs(k, kind)) begin
          got = observe(k, kind);
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event dut%0d kind%0d: got %h expected none", k, kind, got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL event dut%0d kind%0d: got %h expected %h", k, kind, got, e);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_hs(input int k, input int kind, input string nm, output int cyc);
    logic found;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < TMO) begin
      @(negedge clk);
      cyc++;
      if (hs(k, kind)) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s dut%0d: got no handshake expected one within %0d cycles", nm, k, TMO);
    end
  endtask

  task automatic set_ar(input int k, input logic [31:0] addr, input logic [7:0] len);
    sxarid = 4'h3; sxaraddr = addr; sxarlen = len; sxarsize = 3'd2; sxarburst = 2'd1;
    sxarvalid[k] = 1'b1;
  endtask

  task automatic set_aw(input int k, input logic [31:0] addr, input logic [7:0] len);
    sxawid = 4'h5; sxawaddr = addr; sxawlen = len; sxawsize = 3'd2; sxawburst = 2'd1;
    sxawvalid[k] = 1'b1;
  endtask

  // AR handshake is expected one cycle after the request reaches an idle block
  task automatic do_read(input int k, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input int lastbeat, input int errbeat);
    int c;
    logic [31:0] d;
    set_ar(k, addr, len);
    exp_q.push_back(mk(k, K_AR, 4'h3, 5'b01001, addr, len, 1'b0));
    wait_hs(k, K_AR, "ar", c);
    chk("ar_latency", c, 2);
    @(posedge clk); #1;
    sxarvalid[k] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = 32'hA000_0000 + addr + 32'(b);
      mxrid = 4'h3; mxrdata = d; mxrresp = (b == errbeat) ? 2'd2 : 2'd0;
      mxrlast = (b == lastbeat); mxrvalid[k] = 1'b1;
      exp_q.push_back(mk(k, K_R, 4'h3, 5'd0, d, {6'd0, mxrresp}, mxrlast));
      wait_hs(k, K_R, "r", c);
      @(posedge clk); #1;
    end
    mxrvalid[k] = 1'b0; mxrlast = 1'b0; mxrresp = 2'd0;
  endtask

  task automatic do_write(input int k, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input logic [1:0] bresp);
    int c;
    logic [31:0] d;
    set_aw(k, addr, len);
    exp_q.push_back(mk(k, K_AW, 4'h5, 5'b01001, addr, len, 1'b0));
    wait_hs(k, K_AW, "aw", c);
    chk("aw_latency", c, 2);
    @(posedge clk); #1;
    sxawvalid[k] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = 32'hB000_0000 + addr + 32'(b);
      sxwid = 4'h5; sxwdata = d; sxwstrb = 4'hF - 4'(b);
      sxwlast = (b == nbeats - 1); sxwvalid[k] = 1'b1;
      exp_q.push_back(mk(k, K_W, 4'h5, 5'd0, d, {4'h0, sxwstrb}, sxwlast));
      wait_hs(k, K_W, "w", c);
      @(posedge clk); #1;
    end
    sxwvalid[k] = 1'b0; sxwlast = 1'b0;
    mxbid = 4'h5; mxbresp = bresp; mxbvalid[k] = 1'b1;
    exp_q.push_back(mk(k, K_B, 4'h5, 5'd0, 32'd0, {6'd0, bresp}, 1'b0));
    wait_hs(k, K_B, "b", c);
    @(posedge clk); #1;
    mxbvalid[k] = 1'b0; mxbresp = 2'd0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    rstnn = 1'b0; clear = 1'b0;
    sxarvalid = '0; sxawvalid = '0; sxwvalid = '0; mxrvalid = '0; mxbvalid = '0;
    sxarid = '0; sxaraddr = '0; sxarlen = '0; sxarsize = '0; sxarburst = '0;
    sxawid = '0; sxawaddr = '0; sxawlen = '0; sxawsize = '0; sxawburst = '0;
    sxwid = '0; sxwdata = '0; sxwstrb = '0; sxwlast = 1'b0;
    mxrid = '0; mxrdata = '0; mxrresp = '0; mxrlast = 1'b0;
    mxbid = '0; mxbresp = '0;
    sxrready = 1'b1; sxbready = 1'b1; mxarready = 1'b1; mxawready = 1'b1; mxwready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_outputs_dut0", 32'(zero_vec(0)), 0);
    chk("reset_outputs_dut1", 32'(zero_vec(1)), 0);
    @(posedge clk); #1 rstnn = 1'b1;

    // burst read, len 3
    do_read(0, 32'h100, 8'd3, 4, 3, -1);
    @(negedge clk);
    chk("read_done_busy_err", {busy[0], error_rresp[0], error_bresp[0], error_rlast[0]}, 0);

    // simultaneous AR/AW: write wins on dut0
    @(posedge clk); #1;
    set_ar(0, 32'h200, 8'd0);
    do_write(0, 32'h300, 8'd3, 4, 2'd0);
    do_read(0, 32'h200, 8'd0, 1, 0, -1);
    @(negedge clk);
    chk("wp1_done_busy", busy[0], 0);

    // simultaneous AR/AW: read wins on dut1
    @(posedge clk); #1;
    set_aw(1, 32'h300, 8'd3);
    do_read(1, 32'h200, 8'd0, 1, 0, -1);
    do_write(1, 32'h300, 8'd3, 4, 2'd0);
    @(negedge clk);
    chk("wp0_done_busy", busy[1], 0);

    // sticky response errors
    @(posedge clk); #1;
    do_read(0, 32'h400, 8'd1, 2, 1, 0);
    @(negedge clk);
    chk("rresp_set", error_rresp[0], 1);
    repeat (3) @(negedge clk);
    chk("rresp_hold", error_rresp[0], 1);
    @(posedge clk); #1;
    do_write(0, 32'h500, 8'd0, 1, 2'd3);
    @(negedge clk);
    chk("bresp_set", error_bresp[0], 1);
    pulse_clear();
    @(negedge clk);
    chk("clear_both", {error_rresp[0], error_bresp[0]}, 0);

    // clear held while a new rresp error arrives
    @(posedge clk); #1 clear = 1'b1;
    do_read(0, 32'h600, 8'd0, 1, 0, 0);
    clear = 1'b0;
    @(negedge clk);
    chk("set_beats_clear", error_rresp[0], 1);
    pulse_clear();

    // early rlast: len 3, rlast on beat 1
    @(posedge clk); #1;
    do_read(0, 32'h700, 8'd3, 2, 1, -1);
    @(negedge clk);
    chk("early_rlast_flag_busy", {error_rlast[0], busy[0]}, 2'b10);
    pulse_clear();
    @(negedge clk);
    chk("rlast_cleared", error_rlast[0], 0);

    // late rlast: len 1, rlast on beat 3
    @(posedge clk); #1;
    do_read(0, 32'h800, 8'd1, 4, 3, -1);
    @(negedge clk);
    chk("late_rlast_flag_busy", {error_rlast[0], busy[0]}, 2'b10);

    // reset during write beat 2 of 4
    @(posedge clk); #1;
    set_aw(0, 32'h900, 8'd3);
    exp_q.push_back(mk(0, K_AW, 4'h5, 5'b01001, 32'h900, 8'd3, 1'b0));
    wait_hs(0, K_AW, "aw_rst", c);
    @(posedge clk); #1 sxawvalid[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      sxwid = 4'h5; sxwdata = 32'hC000_0000 + 32'(b); sxwstrb = 4'hF; sxwlast = 1'b0;
      sxwvalid[0] = 1'b1;
      exp_q.push_back(mk(0, K_W, 4'h5, 5'd0, sxwdata, 8'h0F, 1'b0));
      wait_hs(0, K_W, "w_rst", c);
      @(posedge clk); #1;
    end
    sxwdata = 32'hC000_0002;
    #2;
    chk("wr_beat2_presented", mxwvalid[0], 1);
    rstnn = 1'b0;
    #1;
    chk("reset_midburst_outputs", 32'(zero_vec(0)), 0);
    sxwvalid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rstnn = 1'b1;
    @(posedge clk); #1;
    do_read(0, 32'hA00, 8'd0, 1, 0, -1);
    @(negedge clk);
    chk("post_reset_read", {busy[0], error_rresp[0], error_bresp[0], error_rlast[0]}, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
